alu_8bit: RTL and testbench
===========================

ALU_8BIT -- requirements
Module: alu_8bit

Interface
REQ-001 Parameter: WIDTH, default 8, operand width; ALU_Out is 2*WIDTH bits; only WIDTH=8 is verified.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 A  input  8  operand A, unsigned.
REQ-005 B  input  8  operand B, unsigned.
REQ-006 Opcode  input  4  operation select.
REQ-007 ALU_Out  output  16  registered result.
REQ-008 CarryOut  output  1  registered carry/flag.

Function
REQ-009 The block SHALL compute combinationally from A, B and Opcode, then register ALU_Out and CarryOut on every rising clk edge; latency exactly 1 cycle, no handshake, no stall.
REQ-010 Narrow results (8 or 9 bits) SHALL be zero-extended into ALU_Out[15:0].
REQ-011 Opcode 0 ADD: ALU_Out = {8'h00, (A+B)[7:0]}; CarryOut = (A+B)[8].
REQ-012 Opcode 1 SUB: ALU_Out = {8'h00, (A-B) mod 256}; CarryOut = 1 when A < B (borrow).
REQ-013 Opcode 2 MUL: ALU_Out = A*B full 16-bit product; CarryOut = 1 when product[15:8] != 0.
REQ-014 Opcode 3 DIV: ALU_Out = {A mod B, A div B}; CarryOut = 0; when B = 0: ALU_Out = 16'hFFFF, CarryOut = 1.
REQ-015 Opcode 4 SHL: ALU_Out = {8'h00, A<<1}; CarryOut = A[7].
REQ-016 Opcode 5 SHR: ALU_Out = {8'h00, A>>1}; CarryOut = A[0].
REQ-017 Opcode 6 ROL: ALU_Out = {8'h00, A[6:0], A[7]}; CarryOut = 0.
REQ-018 Opcode 7 ROR: ALU_Out = {8'h00, A[0], A[7:1]}; CarryOut = 0.
REQ-019 Opcodes 8..13 SHALL be bitwise AND, OR, XOR, NOR, NAND, XNOR of A and B in the low byte; CarryOut = 0.
REQ-020 Opcode 14 GT: ALU_Out = 16'h0001 when A > B, else 16'h0000; CarryOut = 0.
REQ-021 Opcode 15 EQ: ALU_Out = 16'h0001 when A == B, else 16'h0000; CarryOut = 0.
REQ-022 Opcode changes between consecutive cycles SHALL each produce their own result one cycle later, with no residue from the previous operation.

Reset
REQ-023 While rst_n = 0, ALU_Out = 16'h0000 and CarryOut = 0, regardless of clk.
REQ-024 Reset assertion mid-operation SHALL clear outputs immediately and asynchronously; the first result after deassertion appears at the first rising edge with rst_n = 1.

Structure
REQ-025 The opcode encodings (16 named constants) SHALL live in a shared package, alu_pkg.
REQ-026 One sub-module, alu_comb (purely combinational result/carry generation), SHALL be instantiated and followed by the output register in alu_8bit.

Verification
REQ-027 Reset: rst_n=0 with outputs previously nonzero -> ALU_Out=0, CarryOut=0 without waiting for a clk edge.
REQ-028 ADD: A=8'hFF, B=8'h01, Opcode=0 -> next cycle ALU_Out=16'h0000, CarryOut=1; A=8'h12, B=8'h34 -> 16'h0046, CarryOut=0.
REQ-029 SUB/MUL: A=8'h05, B=8'h07, Opcode=1 -> 16'h00FE, CarryOut=1; A=8'hFF, B=8'hFF, Opcode=2 -> 16'hFE01, CarryOut=1.
REQ-030 DIV: A=8'd100, B=8'd7, Opcode=3 -> 16'h020E, CarryOut=0; B=0 -> 16'hFFFF, CarryOut=1.
REQ-031 Shift/rotate: A=8'h81, Opcodes 4,5,6,7 -> 16'h0002/C=1, 16'h0040/C=1, 16'h0003/C=0, 16'h00C0/C=0.
REQ-032 Logic/compare: A=8'hF0, B=8'h3C, Opcodes 8..15 on successive cycles -> 0030, 00FC, 00CC, 0003, 00CF, 0033, 0001, 0000, each one cycle after its opcode is applied.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode encodings for the 8-bit ALU and its combinational core.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_MUL  = 4'd2,
    OP_DIV  = 4'd3,
    OP_SHL  = 4'd4,
    OP_SHR  = 4'd5,
    OP_ROL  = 4'd6,
    OP_ROR  = 4'd7,
    OP_AND  = 4'd8,
    OP_OR   = 4'd9,
    OP_XOR  = 4'd10,
    OP_NOR  = 4'd11,
    OP_NAND = 4'd12,
    OP_XNOR = 4'd13,
    OP_GT   = 4'd14,
    OP_EQ   = 4'd15
  } opcode_t;

endpackage

// File: rtl/alu_comb.sv
// Purely combinational ALU core: result and carry/flag from operands and opcode.
module alu_comb
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [3:0]         opcode,
  output logic [2*WIDTH-1:0] result,
  output logic               carry
);

  localparam logic [WIDTH-1:0] ZERO = '0;

  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic [2*WIDTH-1:0] product;

  assign sum     = {1'b0, a} + {1'b0, b};
  assign diff    = {1'b0, a} - {1'b0, b};
  assign product = {ZERO, a} * {ZERO, b};

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs; otherwise latches are inferred.
    result = '0;
    carry  = 1'b0;
    case (opcode)
      OP_ADD: begin
        result = {ZERO, sum[WIDTH-1:0]};
        carry  = sum[WIDTH];
      end
      OP_SUB: begin
        // The extra MSB of the widened difference is the borrow (a < b).
        result = {ZERO, diff[WIDTH-1:0]};
        carry  = diff[WIDTH];
      end
      OP_MUL: begin
        result = product;
        carry  = |product[2*WIDTH-1:WIDTH];
      end
      OP_DIV: begin
        if (b == ZERO) begin
          result = '1;
          carry  = 1'b1;
        end else begin
          result = {a % b, a / b};
        end
      end
      OP_SHL: begin
        result = {ZERO, a << 1};
        carry  = a[WIDTH-1];
      end
      OP_SHR: begin
        result = {ZERO, a >> 1};
        carry  = a[0];
      end
      OP_ROL:  result = {ZERO, a[WIDTH-2:0], a[WIDTH-1]};
      OP_ROR:  result = {ZERO, a[0], a[WIDTH-1:1]};
      OP_AND:  result = {ZERO, a & b};
      OP_OR:   result = {ZERO, a | b};
      OP_XOR:  result = {ZERO, a ^ b};
      OP_NOR:  result = {ZERO, ~(a | b)};
      OP_NAND: result = {ZERO, ~(a & b)};
      OP_XNOR: result = {ZERO, ~(a ^ b)};
      OP_GT:   result = {{(2*WIDTH-1){1'b0}}, a > b};
      OP_EQ:   result = {{(2*WIDTH-1){1'b0}}, a == b};
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_8bit.sv
// Registered ALU: combinational core followed by a single output register stage.
module alu_8bit
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic [3:0]         Opcode,
  output logic [2*WIDTH-1:0] ALU_Out,
  output logic               CarryOut
);

  logic [2*WIDTH-1:0] result;
  logic               carry;

  alu_comb #(.WIDTH(WIDTH)) u_comb (
    .a      (A),
    .b      (B),
    .opcode (Opcode),
    .result (result),
    .carry  (carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ALU_Out  <= '0;
      CarryOut <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments for registered state avoid simulation races between flops.
      ALU_Out  <= result;
      CarryOut <= carry;
    end
  end

endmodule

// File: tb/tb_alu_8bit.sv
// Self-checking bench for alu_8bit: scoreboard queue of expected results, one cycle latency.
module tb_alu_8bit;
  import alu_pkg::*;

  typedef struct packed {
    logic [15:0] out;
    logic        c;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [7:0]  A;
  logic [7:0]  B;
  logic [3:0]  Opcode;
  logic [15:0] ALU_Out;
  logic        CarryOut;

  exp_t sb[$];
  int   vectors;
  int   miscompares;

  alu_8bit #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .A        (A),
    .B        (B),
    .Opcode   (Opcode),
    .ALU_Out  (ALU_Out),
    .CarryOut (CarryOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent reference model written with integer arithmetic.
  function automatic exp_t model(input int a, input int b, input int op);
    int   o;
    int   c;
    exp_t e;
    o = 0;
    c = 0;
    case (op)
      0:  begin o = (a + b) % 256; c = (a + b) / 256; end
      1:  begin o = (a - b + 256) % 256; c = (a < b) ? 1 : 0; end
      2:  begin o = a * b; c = (a * b > 255) ? 1 : 0; end
      3:  if (b == 0) begin o = 65535; c = 1; end
          else o = (a % b) * 256 + a / b;
      4:  begin o = (a * 2) % 256; c = a / 128; end
      5:  begin o = a / 2; c = a % 2; end
      6:  o = (a * 2) % 256 + a / 128;
      7:  o = a / 2 + (a % 2) * 128;
      8:  o = a & b;
      9:  o = a | b;
      10: o = a ^ b;
      11: o = 255 - (a | b);
      12: o = 255 - (a & b);
      13: o = 255 - (a ^ b);
      14: o = (a > b) ? 1 : 0;
      15: o = (a == b) ? 1 : 0;
      default: o = 0;
    endcase
    e.out = 16'(o);
    e.c   = (c != 0);
    return e;
  endfunction

  task automatic compare_head(input string name);
    exp_t e;
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $display("FAIL %s: scoreboard empty, got %h/%b", name, ALU_Out, CarryOut);
    end else begin
      e = sb.pop_front();
      if ({ALU_Out, CarryOut} !== {e.out, e.c}) begin
        miscompares++;
        $display("FAIL %s: got ALU_Out=%h C=%b, expected ALU_Out=%h C=%b",
                 name, ALU_Out, CarryOut, e.out, e.c);
      end
    end
  endtask

  // Drive on the falling edge, compare just after the next rising edge.
  task automatic step(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                      input logic [15:0] eo, input logic ec, input string name);
    exp_t e;
    @(negedge clk);
    A = a; B = b; Opcode = op;
    e.out = eo; e.c = ec;
    sb.push_back(e);
    @(posedge clk);
    #1;
    compare_head(name);
  endtask

  task automatic check_zero(input string name);
    vectors++;
    if ({ALU_Out, CarryOut} !== 17'h0) begin
      miscompares++;
      $display("FAIL %s: got ALU_Out=%h C=%b, expected 0000/0", name, ALU_Out, CarryOut);
    end
  endtask

  task automatic test_reset();
    exp_t e;
    #3;
    check_zero("reset_initial");
    @(negedge clk);
    rst_n = 1'b1;
    step(8'hFF, 8'hFF, OP_ADD, 16'h00FE, 1'b1, "pre_reset_add");
    #1;
    rst_n = 1'b0;
    #1;
    check_zero("reset_async_clear");
    A = 8'hFF; B = 8'hFF; Opcode = OP_MUL;
    @(posedge clk);
    #1;
    check_zero("reset_hold_over_edge");
    @(negedge clk);
    A = 8'h12; B = 8'h34; Opcode = OP_ADD;
    rst_n = 1'b1;
    e.out = 16'h0046; e.c = 1'b0;
    sb.push_back(e);
    @(posedge clk);
    #1;
    compare_head("first_after_release");
  endtask

  task automatic test_arith();
    step(8'hFF, 8'h01, OP_ADD, 16'h0000, 1'b1, "add_carry");
    step(8'h12, 8'h34, OP_ADD, 16'h0046, 1'b0, "add_plain");
    step(8'h05, 8'h07, OP_SUB, 16'h00FE, 1'b1, "sub_borrow");
    step(8'h07, 8'h05, OP_SUB, 16'h0002, 1'b0, "sub_plain");
    step(8'hFF, 8'hFF, OP_MUL, 16'hFE01, 1'b1, "mul_max");
    step(8'h0F, 8'h03, OP_MUL, 16'h002D, 1'b0, "mul_small");
    step(8'd100, 8'd7, OP_DIV, 16'h020E, 1'b0, "div_plain");
    step(8'd100, 8'd0, OP_DIV, 16'hFFFF, 1'b1, "div_by_zero");
  endtask

  task automatic test_shift();
    step(8'h81, 8'h00, OP_SHL, 16'h0002, 1'b1, "shl");
    step(8'h81, 8'h00, OP_SHR, 16'h0040, 1'b1, "shr");
    step(8'h81, 8'h00, OP_ROL, 16'h0003, 1'b0, "rol");
    step(8'h81, 8'h00, OP_ROR, 16'h00C0, 1'b0, "ror");
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_lc [8];
    exp_lc = '{16'h0030, 16'h00FC, 16'h00CC, 16'h0003,
               16'h00CF, 16'h0033, 16'h0001, 16'h0000};
    for (int i = 0; i < 8; i++)
      step(8'hF0, 8'h3C, 4'(8 + i), exp_lc[i], 1'b0, $sformatf("logic_cmp_op%0d", 8 + i));
    step(8'h5A, 8'h5A, OP_EQ, 16'h0001, 1'b0, "eq_true");
    step(8'h5A, 8'h5A, OP_GT, 16'h0000, 1'b0, "gt_equal");
  endtask

  task automatic test_random();
    int   a;
    int   b;
    int   op;
    exp_t e;
    for (int i = 0; i < 64; i++) begin
      a  = int'($urandom_range(255));
      b  = (i % 8 == 0) ? 0 : int'($urandom_range(255));
      op = int'($urandom_range(15));
      e  = model(a, b, op);
      step(8'(a), 8'(b), 4'(op), e.out, e.c, $sformatf("rand%0d_op%0d", i, op));
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n  = 1'b0;
    A      = 8'h00;
    B      = 8'h00;
    Opcode = 4'h0;
    test_reset();
    test_arith();
    test_shift();
    test_back_to_back();
    test_random();
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
